// File: rtl/ram_wait_pkg.sv
// Shared types, constants and address decode for the ram_wait SRAM peripheral.
package ram_wait_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Geometry of the default 32-bit x 1024-word configuration; instances
  // derive their own values from their parameters.
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 1024;
  localparam int BE_W       = DEF_DATA_W / 8;
  localparam int IDX_W      = $clog2(DEF_DEPTH);
  localparam int LSB_W      = $clog2(BE_W);

  localparam int BYTE_W = 8;
  // Wide enough for WAIT_STATES up to 15.
  localparam int CNT_W  = 4;

  typedef struct packed {
    logic        hit;
    logic [63:0] idx;
  } decode_t;

  // Addresses are zero-extended to 64 bits by the caller. The explicit
  // addr >= base test keeps addresses below the region from wrapping into it.
  function automatic decode_t decode_addr(input logic [63:0] addr,
                                          input logic [63:0] base,
                                          input int unsigned lsb_w,
                                          input logic [63:0] depth);
    decode_t     d;
    logic [63:0] off;
    logic [63:0] mask;
    off   = addr - base;
    mask  = (64'd1 << lsb_w) - 64'd1;
    d.idx = off >> lsb_w;
    d.hit = (addr >= base) && (d.idx < depth) && ((addr & mask) == 64'd0);
    return d;
  endfunction

endpackage

// File: rtl/ram_wait_array.sv
// Word storage with byte-lane writes and a registered, enabled read port.
// No reset so it can map onto block RAM.
module ram_wait_array
  import ram_wait_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic                       re,
  input  logic [DATA_W/8-1:0]        be,
  input  logic [$clog2(DEPTH)-1:0]   idx,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Lane-masked write; the read register only loads on a read so the
  // response word holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DATA_W / BYTE_W; i++) begin
        if (be[i]) mem[idx][BYTE_W*i +: BYTE_W] <= wdata[BYTE_W*i +: BYTE_W];
      end
    end
    if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/ram_wait.sv
// Single-port SRAM peripheral: request/response handshake, base-address
// decode with alignment/range errors, and configurable wait states.
module ram_wait
  import ram_wait_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                DEPTH       = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                WAIT_STATES = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int          BE_N  = DATA_W / 8;
  localparam int          IDX_N = $clog2(DEPTH);
  localparam int unsigned LSB_N = $clog2(BE_N);
  localparam logic [CNT_W-1:0] WAIT_LOAD =
    (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  wait_cnt;
  decode_t           dec;
  logic [IDX_N-1:0]  idx;
  logic              accept;
  logic              arr_we, arr_re;
  logic [DATA_W-1:0] arr_rdata;
  logic              rd_hit_q, err_q;
  logic              unused_idx_hi;

  assign dec           = decode_addr(64'(req_addr), 64'(BASE_ADDR), LSB_N, 64'(DEPTH));
  assign idx           = dec.idx[IDX_N-1:0];
  assign unused_idx_hi = ^dec.idx[63:IDX_N];

  assign accept = req_valid && req_ready;
  assign arr_we = accept && req_we && dec.hit;
  assign arr_re = accept && !req_we && dec.hit;

  ram_wait_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (arr_re),
    .be    (req_be),
    .idx   (idx),
    .wdata (req_wdata),
    .rdata (arr_rdata)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state and handshake outputs; ready is held low while in reset.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = rst;
        if (req_valid && rst) state_nxt = (WAIT_STATES == 0) ? RESP : WAIT;
      end
      WAIT: begin
        if (wait_cnt == '0) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Wait-state counter: loaded on accept, counts down to zero in WAIT.
  always_ff @(posedge clk) begin
    if (!rst)                                wait_cnt <= '0;
    else if (accept)                         wait_cnt <= WAIT_LOAD;
    else if (state == WAIT && wait_cnt != 0) wait_cnt <= wait_cnt - 1'b1;
  end

  // Response kind captured on accept; the read word itself lives in the array register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_hit_q <= 1'b0;
      err_q    <= 1'b0;
    end else if (accept) begin
      rd_hit_q <= arr_re;
      err_q    <= !dec.hit;
    end
  end

  assign rsp_rdata = (rsp_valid && rd_hit_q) ? arr_rdata : '0;
  assign rsp_err   = rsp_valid && err_q;

endmodule

// File: tb/tb_ram_wait.sv
// Directed bench for ram_wait: one instance without wait states, one with three.
module tb_ram_wait;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic        rst       [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  ram_wait #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  ram_wait #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] mdl [2][DEPTH];
  int          acc_cyc  [2];
  logic        prev_vld [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit b_hit(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (a >= BASE) && (off < 32'(4 * DEPTH)) && (a[1:0] == 2'b00);
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  // Waits for ready, drives one request, pushes its expected response and
  // returns just after the accepting edge.
  task automatic issue(input int d, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    exp_t e;
    int   n;
    int   idx;
    n = 0;
    while (!req_ready[d] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("ready_timeout", 32'(req_ready[d]), 32'd1);
    idx     = int'((addr - BASE) >> 2);
    e.err   = !b_hit(addr);
    e.rdata = '0;
    if (!e.err) begin
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) mdl[d][idx][8*i +: 8] = wdata[8*i +: 8];
      end else begin
        e.rdata = mdl[d][idx];
      end
    end
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_be[d]    = be;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    @(posedge clk); #1;
    acc_cyc[d]   = cyc;
    req_valid[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while (qsize(d) != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 32'(qsize(d)), 32'd0);
  endtask

  task automatic wait_valid(input int d);
    int n;
    n = 0;
    while (!rsp_valid[d] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) chk("valid_timeout", 32'(rsp_valid[d]), 32'd1);
  endtask

  // Scoreboard: latency on every rising rsp_valid, payload on every handshake.
  always @(negedge clk) begin : monitor
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (rst[d] && rsp_valid[d] && !prev_vld[d])
        chk((d == 0) ? "latency_ws0" : "latency_ws3", 32'(cyc - acc_cyc[d] + 1), 32'(1 + 3 * d));
      if (rst[d] && rsp_valid[d] && rsp_ready[d]) begin
        if (qsize(d) == 0) begin
          chk("unexpected_rsp", 32'(rsp_valid[d]), 32'd0);
        end else begin
          if (d == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          chk("rsp_rdata", rsp_rdata[d], e.rdata);
          chk("rsp_err", 32'(rsp_err[d]), 32'(e.err));
        end
      end
      prev_vld[d] = rsp_valid[d];
    end
  end

  initial begin
    int n;
    int prev_acc;
    for (int d = 0; d < 2; d++) begin
      rst[d]       = 1'b0;
      req_valid[d] = 1'b0;
      req_we[d]    = 1'b0;
      req_addr[d]  = '0;
      req_wdata[d] = '0;
      req_be[d]    = '0;
      rsp_ready[d] = 1'b1;
      prev_vld[d]  = 1'b0;
      acc_cyc[d]   = 0;
    end
    repeat (3) @(posedge clk);
    #1;

    // Reset state on both instances.
    for (int d = 0; d < 2; d++) begin
      chk("rst_req_ready", 32'(req_ready[d]), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata[d], 32'd0);
      chk("rst_rsp_err", 32'(rsp_err[d]), 32'd0);
    end
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready_ws0", 32'(req_ready[0]), 32'd1);
    chk("idle_ready_ws3", 32'(req_ready[1]), 32'd1);

    // Zero wait states: word, byte lanes, errors, no-op write.
    issue(0, 1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF);
    issue(0, 1'b0, BASE + 32'h10, 32'h0, 4'h0);
    issue(0, 1'b1, BASE + 32'h20, 32'h1122_3344, 4'hF);
    issue(0, 1'b1, BASE + 32'h20, 32'hAABB_CCDD, 4'b0101);
    issue(0, 1'b0, BASE + 32'h20, 32'h0, 4'h0);
    issue(0, 1'b1, BASE, 32'h0123_4567, 4'hF);
    issue(0, 1'b0, BASE + 32'h1002, 32'h0, 4'h0);
    issue(0, 1'b1, BASE + 32'(4 * DEPTH), 32'hFFFF_FFFF, 4'hF);
    issue(0, 1'b0, BASE, 32'h0, 4'h0);
    issue(0, 1'b0, BASE - 32'h4, 32'h0, 4'h0);
    issue(0, 1'b1, BASE + 32'h10, 32'h7777_7777, 4'h0);
    issue(0, 1'b0, BASE + 32'h10, 32'h0, 4'h0);
    issue(0, 1'b0, BASE + 32'hFFC, 32'h0, 4'h0);

    // Back-to-back with rsp_ready held high: one accept every two cycles.
    prev_acc = acc_cyc[0];
    for (int i = 0; i < 6; i++) begin
      issue(0, (i % 2) == 0, BASE + 32'h100 + 32'(4 * (i / 2)), 32'hC0DE_0000 + 32'(i), 4'hF);
      chk("b2b_gap", 32'(acc_cyc[0] - prev_acc), 32'd2);
      prev_acc = acc_cyc[0];
    end
    drain(0);

    // Three wait states: ready stays low until the response appears.
    issue(1, 1'b1, BASE + 32'h20, 32'h5A5A_A5A5, 4'hF);
    issue(1, 1'b0, BASE + 32'h20, 32'h0, 4'h0);
    n = 0;
    while (!rsp_valid[1] && n < 20) begin
      chk("ready_low_wait", 32'(req_ready[1]), 32'd0);
      @(posedge clk); #1;
      n++;
    end
    chk("wait_cycles", 32'(n), 32'd3);
    drain(1);

    // Stalled consumer: response held, a competing request is refused.
    rsp_ready[1] = 1'b0;
    issue(1, 1'b0, BASE + 32'h20, 32'h0, 4'h0);
    wait_valid(1);
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b0;
    req_addr[1]  = BASE;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(rsp_valid[1]), 32'd1);
      chk("hold_rdata", rsp_rdata[1], 32'h5A5A_A5A5);
      chk("hold_err", 32'(rsp_err[1]), 32'd0);
      chk("hold_ready", 32'(req_ready[1]), 32'd0);
    end
    req_valid[1] = 1'b0;
    rsp_ready[1] = 1'b1;
    drain(1);

    // Reset while counting wait states: response dropped, write kept.
    issue(1, 1'b1, BASE + 32'h40, 32'hCAFE_F00D, 4'hF);
    rst[1] = 1'b0;
    q1.delete();
    @(posedge clk); #1;
    chk("midrst_req_ready", 32'(req_ready[1]), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid[1]), 32'd0);
    chk("midrst_rsp_rdata", rsp_rdata[1], 32'd0);
    chk("midrst_rsp_err", 32'(rsp_err[1]), 32'd0);
    rst[1] = 1'b1;
    @(posedge clk); #1;
    chk("postrst_ready", 32'(req_ready[1]), 32'd1);
    issue(1, 1'b0, BASE + 32'h40, 32'h0, 4'h0);
    drain(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
